// File: rtl/shift_pkg.sv
// Shared types and sizes for the sequential logical left shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int UINT8_WIDTH       = 8;
  localparam int UINT8_SHIFT_WIDTH = 3;

endpackage

// File: rtl/shift_l_stage.sv
// One step of the multicycle left shifter: shift by 1<<cnt when enabled, zero-fill.
module shift_l_stage #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 3,
  localparam int CNT_W      = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  output logic [WIDTH-1:0] acc_nxt
);

  always_comb begin
    acc_nxt = acc;
    if (en) acc_nxt = acc << (32'd1 << cnt);
  end

endmodule

// File: rtl/shift_l_uint8_seq.sv
// Multicycle unsigned logical left shifter, one shift-amount bit per cycle,
// with ready/valid handshakes on operands and result.
module shift_l_uint8_seq
  import shift_pkg::*;
#(
  parameter int WIDTH       = UINT8_WIDTH,
  parameter int SHIFT_WIDTH = UINT8_SHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             busy
);

  localparam int CNT_W = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_WIDTH - 1);

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       acc, acc_nxt, y_q;
  logic [SHIFT_WIDTH-1:0] amt;
  logic [CNT_W-1:0]       cnt;
  logic                   out_valid_q;
  logic                   last_step;

  // Only the low shift-amount bits matter; the rest of B is deliberately ignored.
  logic unused_b_hi;
  assign unused_b_hi = ^B[WIDTH-1:SHIFT_WIDTH];

  shift_l_stage #(
    .WIDTH      (WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_stage (
    .acc    (acc),
    .cnt    (cnt),
    .en     (amt[cnt]),
    .acc_nxt(acc_nxt)
  );

  assign last_step = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      amt         <= '0;
      cnt         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= A;
            amt <= B[SHIFT_WIDTH-1:0];
            cnt <= '0;
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            y_q         <= acc_nxt;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign Y         = y_q;

endmodule

// File: doc/shift_l_uint8_seq.md
Name: shift_l_uint8_seq

Overview:
- Multicycle unsigned 8-bit logical left shifter, Y = (A << B[2:0]) truncated to WIDTH bits.
- It is the left-shift counterpart of the team's combinational right-shift benchmark, and consumes B the same way: only the low SHIFT_WIDTH bits are used.
- It processes one shift-amount bit per cycle (shift by 1, 2, 4, ...), exposing a ready/valid handshake on both input and output.
- It serves as a sequential benchmark and building block in the pimsynth flow.

Parameters:
- WIDTH, 8, data width of A, B and Y.
- SHIFT_WIDTH, 3, number of B bits used. Must equal clog2(WIDTH). This is also the number of SHIFT cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  WIDTH  value to shift.
- B  input  WIDTH  shift amount; only B[SHIFT_WIDTH-1:0] is used, upper bits are ignored.
- out_valid  output  1  Y holds a completed result.
- out_ready  input  1  consumer accepts Y.
- Y  output  WIDTH  registered result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, amt=0, cnt=0, Y=0, out_valid=0, busy=0. in_ready=1, because it decodes IDLE combinationally, including during reset.
- States:
  - IDLE: in_ready=1. On in_valid at a clock edge: acc<=A, amt<=B[SHIFT_WIDTH-1:0], cnt<=0, go to SHIFT.
  - SHIFT: each cycle, if amt[cnt] then acc <= acc << (1<<cnt), zero-fill, bits shifted past MSB discarded; else acc holds. cnt<=cnt+1. When cnt==SHIFT_WIDTH-1, also Y<=next acc value, out_valid<=1, go to DONE.
  - DONE: out_valid=1, Y stable. On out_ready: out_valid<=0, go to IDLE. Y keeps its last value in IDLE/SHIFT until the next DONE entry.
- Latency:
  - Operands accepted at edge N; out_valid rises after edge N+SHIFT_WIDTH (3 cycles).
  - Minimum initiation interval is SHIFT_WIDTH+2 = 5 cycles with out_ready tied high.
- Handshake rules:
  - Transfer occurs only when valid and ready are both high at a rising edge.
  - in_valid outside IDLE is ignored; no queuing.
  - out_valid, once high, stays high with Y unchanged until out_ready.
  - in_ready is never high in the same cycle as out_valid.
- Arithmetic: pure logical shift, no sign handling.
  - Shift amount 0 gives Y=A.
  - Shift amount WIDTH-1 leaves only A[0] in the MSB.
  - The result equals (A << B[2:0]) & 8'hFF for all 2^8 × 2^3 cases.
- Boundaries:
  - B upper bits are don't-care.
  - in_valid held high continuously: one capture per IDLE visit.
  - out_ready high on the very cycle DONE is entered: state returns to IDLE at the next edge (out_valid high for exactly 1 cycle).
  - Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is discarded and never presented.
- busy = (state != IDLE).

Decomposition:
- Shared package shift_pkg holds:
  - the state enum: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - localparam UINT8_WIDTH=8 and UINT8_SHIFT_WIDTH=3.
- One natural sub-module, shift_l_stage: combinational, with parameters WIDTH and SHIFT_WIDTH.
  - Inputs are acc, cnt and an enable bit; output is acc shifted left by 1<<cnt when enabled.
  - It is the left-shift mirror of the team's shift_r_nbit style.
- The top level holds the FSM, registers and handshake.

Test Plan:
- A=8'hB5, B=8'h03, out_ready=1 → out_valid 3 cycles after accept, Y=8'hA8, then in_ready returns 1.
- A=8'h13, B=8'h0A (low bits=2) → Y=8'h4C (upper B bits ignored). A=8'hB5, B=8'h00 → Y=8'hB5.
- A=8'hFF, B=8'h07 → Y=8'h80. A=8'h7F, B=8'h07 → Y=8'h80. A=8'h01, B=8'h04 → Y=8'h10.
- Backpressure: out_ready=0 for 4 cycles after DONE, then in_valid pulsed with A=8'h01 during that time → out_valid and Y held steady, in_ready=0, pulse ignored. After out_ready, the next accepted op produces the correct result.
- Reset mid-operation: accept A=8'hB5, B=8'h03, assert rst_n=0 in the 2nd SHIFT cycle → out_valid=0, Y=0, busy=0 and in_ready=1 immediately (asynchronous), with no stale result after release.
- Back-to-back stream: 16 random ops with in_valid and out_ready held high → every Y matches the reference model, and accepts are spaced exactly 5 cycles apart.
